// File: rtl/pie_pkg.sv
// Shared state encoding and default parameters for the PIE command receiver.
package pie_pkg;
   localparam int CNT_W_DEF      = 12;
   localparam int DELIM_MIN_DEF  = 10;
   localparam int DELIM_MAX_DEF  = 20;
   localparam int TIMEOUT_DEF    = 1023;
   localparam int GLITCH_CNT_DEF = 3;

   typedef enum logic [2:0] {
      IDLE, DELIM, TARI, RTCAL, CAL_OR_DATA, DATA
   } pie_state_t;
endpackage

// File: rtl/pie_edge_sync.sv
// Synchronizes the envelope input and emits registered rise/fall strobes and level.
// Optional stability filter on the synchronized level: PIE_GLITCH_FILTER_EN.
module pie_edge_sync
   import pie_pkg::*;
`ifdef PIE_GLITCH_FILTER_EN
#(
   parameter int GLITCH_CNT = GLITCH_CNT_DEF
)
`endif
(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_din,
   output logic o_rise,
   output logic o_fall,
   output logic o_level
);
   logic r_sync1, r_sync2, r_hist, r_rise, r_fall;
   logic w_lvl;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_din;
         r_sync2 <= r_sync1;
      end
   end

`ifdef PIE_GLITCH_FILTER_EN
   localparam int GW = $clog2(GLITCH_CNT + 1);
   localparam logic [GW-1:0] G_LAST = GW'(GLITCH_CNT - 1);
   logic          r_filt;
   logic [GW-1:0] r_gcnt;

   // The level flips only once the new value has been seen GLITCH_CNT cycles in a row.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_filt <= 1'b1;
         r_gcnt <= '0;
      end else if (r_sync2 == r_filt) begin
         r_gcnt <= '0;
      end else if (r_gcnt == G_LAST) begin
         r_filt <= r_sync2;
         r_gcnt <= '0;
      end else begin
         r_gcnt <= r_gcnt + 1'b1;
      end
   end
   assign w_lvl = r_filt;
`else
   assign w_lvl = r_sync2;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hist <= 1'b1;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_hist <= w_lvl;
         r_rise <= w_lvl & ~r_hist;
         r_fall <= ~w_lvl & r_hist;
      end
   end

   assign o_rise  = r_rise;
   assign o_fall  = r_fall;
   assign o_level = r_hist;
endmodule

// File: rtl/pie_decoder.sv
// PIE reader-to-tag receiver: delimiter detect, Tari/RTcal/TRcal measurement, bit slicing.
// Optional input glitch filter: PIE_GLITCH_FILTER_EN.
module pie_decoder
   import pie_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int DELIM_MIN = DELIM_MIN_DEF,
   parameter int DELIM_MAX = DELIM_MAX_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
`ifdef PIE_GLITCH_FILTER_EN
   , parameter int GLITCH_CNT = GLITCH_CNT_DEF
`endif
)(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enabled,
   input  logic             i_demod_in,
   output logic             o_bit_out,
   output logic             o_bit_valid,
   output logic             o_frame_start,
   output logic             o_frame_end,
   output logic             o_error,
   output logic [CNT_W-1:0] o_rtcal,
   output logic [CNT_W-1:0] o_trcal,
   output logic             o_trcal_valid
);
   localparam logic [CNT_W-1:0] C_DMIN = CNT_W'(DELIM_MIN);
   localparam logic [CNT_W-1:0] C_DMAX = CNT_W'(DELIM_MAX);
   localparam logic [CNT_W-1:0] C_TO   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   pie_state_t       r_state, w_nstate;
   logic [CNT_W-1:0] r_cnt, w_ncnt, r_tari, w_ntari;
   logic [CNT_W-1:0] r_rtcal, w_nrtcal, r_trcal, w_ntrcal, w_pivot;
   logic             r_trv, w_ntrv, r_got, w_ngot, r_bit, w_nbit;
   logic             r_bv, w_nbv, r_fs, w_nfs, r_fe, w_nfe, r_err, w_nerr;
   logic             w_rise, w_fall, w_level, w_tmo;

`ifdef PIE_GLITCH_FILTER_EN
   pie_edge_sync #(.GLITCH_CNT(GLITCH_CNT)) u_sync (
`else
   pie_edge_sync u_sync (
`endif
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_din   (i_demod_in),
      .o_rise  (w_rise),
      .o_fall  (w_fall),
      .o_level (w_level)
   );

   assign w_pivot = r_rtcal >> 1;
   assign w_tmo   = ~w_rise && (r_cnt >= C_TO);

   always_comb begin
      w_nstate = r_state;
      w_ncnt   = (r_cnt == '1) ? r_cnt : r_cnt + C_ONE;
      w_ntari  = r_tari;
      w_nrtcal = r_rtcal;
      w_ntrcal = r_trcal;
      w_ntrv   = r_trv;
      w_ngot   = r_got;
      w_nbit   = r_bit;
      w_nbv    = 1'b0;
      w_nfs    = 1'b0;
      w_nfe    = 1'b0;
      w_nerr   = 1'b0;
      if (!i_enabled) begin
         w_nstate = IDLE;
      end else begin
         case (r_state)
            IDLE: if (w_fall) begin
               w_nstate = DELIM;
               w_ncnt   = C_ONE;
               w_ntrv   = 1'b0;
               w_ngot   = 1'b0;
            end
            DELIM: if (w_rise) begin
               w_ncnt = C_ONE;
               if (r_cnt >= C_DMIN && r_cnt <= C_DMAX) w_nstate = TARI;
               else begin
                  w_nstate = IDLE;
                  w_nerr   = 1'b1;
               end
            end else if (!w_level && r_cnt > C_DMAX) begin
               // Overlong delimiter is rejected without waiting for its rising edge.
               w_nstate = IDLE;
               w_nerr   = 1'b1;
            end
            TARI: if (w_rise) begin
               w_ntari  = r_cnt;
               w_ncnt   = C_ONE;
               w_nstate = RTCAL;
            end
            RTCAL: if (w_rise) begin
               w_ncnt = C_ONE;
               if (r_cnt > r_tari) begin
                  w_nrtcal = r_cnt;
                  w_nfs    = 1'b1;
                  w_nstate = CAL_OR_DATA;
               end else begin
                  w_nstate = IDLE;
                  w_nerr   = 1'b1;
               end
            end
            CAL_OR_DATA: if (w_rise) begin
               w_ncnt   = C_ONE;
               w_nstate = DATA;
               if (r_cnt > r_rtcal) begin
                  w_ntrcal = r_cnt;
                  w_ntrv   = 1'b1;
               end else begin
                  w_nbit = (r_cnt > w_pivot);
                  w_nbv  = 1'b1;
                  w_ngot = 1'b1;
               end
            end
            DATA: if (w_rise) begin
               if (r_cnt <= r_rtcal) begin
                  w_ncnt = C_ONE;
                  w_nbit = (r_cnt > w_pivot);
                  w_nbv  = 1'b1;
                  w_ngot = 1'b1;
               end else begin
                  w_nstate = IDLE;
                  w_nerr   = 1'b1;
               end
            end
            default: w_nstate = IDLE;
         endcase
         // A silent line ends the frame cleanly only if it carried data.
         if ((r_state inside {TARI, RTCAL, CAL_OR_DATA, DATA}) && w_tmo) begin
            w_nstate = IDLE;
            w_nfe    = r_got;
            w_nerr   = ~r_got;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_tari  <= '0;
         r_rtcal <= '0;
         r_trcal <= '0;
         r_trv   <= 1'b0;
         r_got   <= 1'b0;
         r_bit   <= 1'b0;
         r_bv    <= 1'b0;
         r_fs    <= 1'b0;
         r_fe    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_tari  <= w_ntari;
         r_rtcal <= w_nrtcal;
         r_trcal <= w_ntrcal;
         r_trv   <= w_ntrv;
         r_got   <= w_ngot;
         r_bit   <= w_nbit;
         r_bv    <= w_nbv;
         r_fs    <= w_nfs;
         r_fe    <= w_nfe;
         r_err   <= w_nerr;
      end
   end

   assign o_bit_out     = r_bit;
   assign o_bit_valid   = r_bv;
   assign o_frame_start = r_fs;
   assign o_frame_end   = r_fe;
   assign o_error       = r_err;
   assign o_rtcal       = r_rtcal;
   assign o_trcal       = r_trcal;
   assign o_trcal_valid = r_trv;
endmodule

// File: tb/tb_pie_decoder.sv
// Self-checking bench for pie_decoder: frame vector table plus reset/enable/glitch sequences.
module tb_pie_decoder;
   localparam int CW  = 12;
   localparam int PW  = 8;
   localparam int TMO = 1023;
`ifdef PIE_GLITCH_FILTER_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 4;
`endif
   localparam int EV_B0 = 0, EV_B1 = 1, EV_FS = 2, EV_FE = 3, EV_ERR = 4;

   typedef struct {
      int d; int t; int r; int c;
      int ns; int s[3];
      int ne; int ev[5];
      int x_rt; int x_tr; int x_trv;
   } vec_t;

   logic          clk = 1'b0, reset = 1'b1, enabled = 1'b1, demod = 1'b1;
   logic          bit_out, bit_valid, frame_start, frame_end, error, trcal_valid;
   logic [CW-1:0] rtcal, trcal;

   int n_cmp = 0, n_fail = 0, cyc = 0, t_bv = 0, t_fe = 0, t_rdrv = 0, multi = 0, rd = 0;
   int obs_q[$];
   int exp_q[$];
   vec_t vt[8];

   pie_decoder dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_enabled     (enabled),
      .i_demod_in    (demod),
      .o_bit_out     (bit_out),
      .o_bit_valid   (bit_valid),
      .o_frame_start (frame_start),
      .o_frame_end   (frame_end),
      .o_error       (error),
      .o_rtcal       (rtcal),
      .o_trcal       (trcal),
      .o_trcal_valid (trcal_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Observed strobes are logged at the falling edge; the main thread scores them.
   always @(negedge clk) begin
      if (bit_valid) begin
         obs_q.push_back(bit_out ? EV_B1 : EV_B0);
         t_bv <= cyc;
      end
      if (frame_start) obs_q.push_back(EV_FS);
      if (frame_end) begin
         obs_q.push_back(EV_FE);
         t_fe <= cyc;
      end
      if (error) obs_q.push_back(EV_ERR);
      if (int'(bit_valid) + int'(frame_end) + int'(error) > 1) multi <= multi + 1;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic score(input string nm);
      int e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd < obs_q.size()) begin
            chk({nm, " event"}, obs_q[rd], e);
            rd++;
         end else chk({nm, " missing event"}, -1, e);
      end
      chk({nm, " extra events"}, obs_q.size() - rd, 0);
      rd = obs_q.size();
      chk({nm, " exclusive strobes"}, multi, 0);
   endtask

   task automatic hold(input logic v, input int n);
      demod = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic sym(input int len);
      t_rdrv = cyc;
      hold(1'b1, len - PW);
      hold(1'b0, PW);
   endtask

   task automatic run_vec(input vec_t v, input string nm, input bit chk_tr);
      for (int i = 0; i < v.ne; i++) exp_q.push_back(v.ev[i]);
      hold(1'b1, 20);
      hold(1'b0, v.d);
      if (v.t > 0) sym(v.t);
      if (v.r > 0) sym(v.r);
      if (v.c > 0) sym(v.c);
      for (int i = 0; i < v.ns; i++) sym(v.s[i]);
      t_rdrv = cyc;
      hold(1'b1, TMO + 40);
      score(nm);
      chk({nm, " rtcal"}, int'(rtcal), v.x_rt);
      if (chk_tr) chk({nm, " trcal"}, int'(trcal), v.x_tr);
      chk({nm, " trcal_valid"}, int'(trcal_valid), v.x_trv);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, " strobes"}, int'({bit_out, bit_valid, frame_start, frame_end, error}), 0);
      chk({nm, " rtcal"}, int'(rtcal), 0);
      chk({nm, " trcal"}, int'(trcal), 0);
      chk({nm, " trcal_valid"}, int'(trcal_valid), 0);
   endtask

   task automatic partial_frame(input int rt, input int bitsym);
      exp_q.push_back(EV_FS);
      exp_q.push_back(EV_B1);
      hold(1'b1, 20);
      hold(1'b0, 15);
      sym(40);
      sym(rt);
      sym(bitsym);
      hold(1'b1, 30);
   endtask

   initial begin
      //         d   t   r    c    ns  syms          ne  events                                   rt   tr  trv
      vt[0] = '{15, 40, 100, 200, 3, '{40, 60, 40},  5, '{EV_FS, EV_B0, EV_B1, EV_B0, EV_FE},    100, 200, 1};
      vt[1] = '{12, 40, 100, 0,   3, '{60, 40, 50},  5, '{EV_FS, EV_B1, EV_B0, EV_B0, EV_FE},    100, 200, 0};
      vt[2] = '{8,  0,  0,   0,   0, '{0, 0, 0},     1, '{EV_ERR, 0, 0, 0, 0},                   100, 200, 0};
      vt[3] = '{25, 0,  0,   0,   0, '{0, 0, 0},     1, '{EV_ERR, 0, 0, 0, 0},                   100, 200, 0};
      vt[4] = '{15, 40, 35,  0,   0, '{0, 0, 0},     1, '{EV_ERR, 0, 0, 0, 0},                   100, 200, 0};
      vt[5] = '{20, 40, 100, 0,   3, '{60, 60, 40},  5, '{EV_FS, EV_B1, EV_B1, EV_B0, EV_FE},    100, 200, 0};
      vt[6] = '{10, 40, 120, 250, 3, '{61, 60, 120}, 5, '{EV_FS, EV_B1, EV_B0, EV_B1, EV_FE},    120, 250, 1};
      vt[7] = '{15, 40, 0,   0,   0, '{0, 0, 0},     1, '{EV_ERR, 0, 0, 0, 0},                   120, 250, 0};

      repeat (3) @(negedge clk);
      chk_reset_vals("por");
      reset = 1'b0;
      repeat (5) @(negedge clk);

      run_vec(vt[0], "vec0", 1'b1);
      chk("vec0 bit latency", t_bv - t_rdrv, LAT);
      chk("vec0 timeout", t_fe - t_bv, TMO);
      for (int i = 1; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i), 1'b1);

      // Reset in the middle of the data phase.
      partial_frame(100, 60);
      reset = 1'b1;
      hold(1'b1, 2);
      chk_reset_vals("mid reset");
      reset = 1'b0;
      hold(1'b1, TMO + 40);
      score("mid reset");
      run_vec(vt[1], "after reset", 1'b0);

      // Enable dropped in the middle of the data phase; calibration values stay latched.
      run_vec(vt[0], "pre enable", 1'b1);
      partial_frame(120, 70);
      enabled = 1'b0;
      hold(1'b1, 10);
      enabled = 1'b1;
      hold(1'b1, TMO + 40);
      score("enable drop");
      chk("enable drop rtcal", int'(rtcal), 120);
      chk("enable drop trcal", int'(trcal), 200);
      run_vec(vt[5], "after enable", 1'b1);

      // Two-cycle high glitch inside a 15-cycle delimiter.
`ifdef PIE_GLITCH_FILTER_EN
      exp_q.push_back(EV_FS);
      exp_q.push_back(EV_B1);
      exp_q.push_back(EV_B0);
      exp_q.push_back(EV_FE);
`else
      repeat (6) exp_q.push_back(EV_ERR);
`endif
      hold(1'b1, 20);
      hold(1'b0, 6);
      hold(1'b1, 2);
      hold(1'b0, 7);
      sym(40);
      sym(100);
      sym(60);
      sym(40);
      hold(1'b1, TMO + 40);
      score("glitch");
      chk("glitch rtcal", int'(rtcal), 100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
